// File: rtl/aes128_inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: walks round keys 10 down to 0 over a valid/ready stream.
// Optional AES_INVKS_KEY0_CAPTURE_EN adds a registered copy of the recovered cipher key.
module aes128_inv_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] last_key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
`ifdef AES_INVKS_KEY0_CAPTURE_EN
    ,
    output logic [0:127] key0,
    output logic         key0_valid
`endif
);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

    state_t       state_q;
    logic [0:127] key_q;
    logic [3:0]   round_q;
    logic [0:127] prev_key;
    logic [31:0]  k0, k1, k2, k3, p0, p1, p2, p3;

    // Undo one forward expansion step: recover key r-1 from key r.
    always_comb begin
        k0 = key_q[0:31];
        k1 = key_q[32:63];
        k2 = key_q[64:95];
        k3 = key_q[96:127];
        p3 = k3 ^ k2;
        p2 = k2 ^ k1;
        p1 = k1 ^ k0;
        p0 = k0 ^ sub_word({p3[23:0], p3[31:24]}) ^ rcon(round_q);
        prev_key = {p0, p1, p2, p3};
    end

`ifdef AES_INVKS_KEY0_CAPTURE_EN
    logic [0:127] key0_q;
    logic         key0_valid_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= '0;
`ifdef AES_INVKS_KEY0_CAPTURE_EN
            key0_q       <= '0;
            key0_valid_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        key_q   <= last_key;
                        round_q <= 4'd10;
                        state_q <= StRun;
`ifdef AES_INVKS_KEY0_CAPTURE_EN
                        key0_valid_q <= 1'b0;
`endif
                    end
                end
                StRun: begin
                    if (rk_ready) begin
                        if (round_q != 4'd0) begin
                            key_q   <= prev_key;
                            round_q <= round_q - 4'd1;
                        end else begin
                            state_q <= StIdle;
`ifdef AES_INVKS_KEY0_CAPTURE_EN
                            key0_q       <= key_q;
                            key0_valid_q <= 1'b1;
`endif
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready = (state_q == StIdle);
    assign rk_valid = (state_q == StRun);
    assign rk       = key_q;
    assign rk_round = round_q;
    assign rk_last  = (state_q == StRun) && (round_q == 4'd0);

`ifdef AES_INVKS_KEY0_CAPTURE_EN
    assign key0       = key0_q;
    assign key0_valid = key0_valid_q;
`endif

endmodule

// File: doc/aes128_inv_key_schedule.md
# aes128_inv_key_schedule

Iterative AES-128 inverse key schedule. It accepts the final (round-10) round key and emits round keys 10, 9, … 0, one per accepted handshake, over a valid/ready stream. It is the reverse-direction companion of the combinational forward key expansion. Its main use is the on-the-fly decryption datapath, which consumes round keys in reverse order without storing all 11 keys.

## Interface
- No parameters. AES-128 only: Nk=4 and Nr=10 are fixed internal constants.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  last_key is presented.
- in_ready  output  1  block is idle and can accept last_key.
- last_key  input  [0:127]  round-10 key; word 0 = bits [0:31], byte 0 = bits [0:7].
- rk_valid  output  1  rk is valid.
- rk_ready  input  1  consumer accepts rk.
- rk  output  [0:127]  current round key, same word/byte ordering as last_key.
- rk_round  output  4  round index of rk, 10 down to 0.
- rk_last  output  1  high while rk_round==0 and rk_valid.

## Operation
- States: IDLE and RUN.
- IDLE:
  - in_ready=1 and rk_valid=0.
  - A load happens when in_valid && in_ready. The key register takes last_key, the round counter takes 10, and the next state is RUN.
- RUN:
  - rk_valid=1 and in_ready=0; in_valid is ignored.
  - On rk_valid && rk_ready with rk_round>0, the key register takes the previous-round key and rk_round decrements.
  - On rk_valid && rk_ready with rk_round==0, the next state is IDLE.
- Inverse step for current key (k0,k1,k2,k3) at round r, with r≥1:
  - p3 = k3^k2
  - p2 = k2^k1
  - p1 = k1^k0
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ Rcon(r)
- Helper functions:
  - RotWord rotates left by one byte: {b1,b2,b3,b0}.
  - SubWord applies the standard AES S-box to each byte.
  - Rcon(r) = {rc[r],24'h0}, where rc[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- The step is combinational from the key register: four S-box lookups, registered once per round.
- Backpressure: while rk_valid && !rk_ready, rk, rk_round and rk_last hold stable.
- Reset values: in_ready=1 (IDLE), rk_valid=0, rk=128'h0, rk_round=0, rk_last=0.
- Reset mid-RUN: the key register and counter clear at the reset edge and the state returns to IDLE. No partial key is emitted after reset deasserts.

## Timing
- Load accepted at edge N: rk_valid=1, rk=last_key, rk_round=10 from cycle N+1.
- With rk_ready held high: one round key per cycle, rounds 10..0 on cycles N+1..N+11.
- Round-0 handshake at edge M: rk_valid=0 and in_ready=1 from cycle M+1. The earliest next load is at edge M+1.
- Minimum load-to-load spacing is 12 cycles.
- Simultaneous rst with any handshake: rst wins.
- in_valid in RUN is dropped; the upstream must hold it until in_ready.

## Configuration
- AES_INVKS_KEY0_CAPTURE_EN defined:
  - Adds output key0 [0:127] and output key0_valid (1).
  - On the round-0 handshake, key0 registers rk (the recovered cipher key) and key0_valid goes to 1.
  - key0_valid clears on the next load or on rst; key0 resets to 0.
- Macro undefined: both ports are absent and behaviour is otherwise identical.

## Test plan
- FIPS-197 A.1 vector, rk_ready=1, load d014f9a8c9ee2589e13f0cc8b6630ca6:
  - rounds 10..0 appear on 11 consecutive cycles;
  - round 9 = ac7766f319fadc2128d12941575c006e;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c with rk_last=1;
  - in_ready=1 on the next cycle.
- Random rk_ready stalls on the same vector: the key sequence is identical, and rk/rk_round hold stable on every stalled cycle.
- in_valid pulsed during RUN with another key: it is ignored, and the output sequence is unchanged.
- rst asserted while rk_round=5: next cycle rk_valid=0, rk=0, in_ready=1. A fresh load then restarts cleanly at round 10.
- Back-to-back loads with in_valid held high: the second key is accepted exactly one cycle after the round-0 handshake (12-cycle spacing).
- With AES_INVKS_KEY0_CAPTURE_EN on the A.1 vector:
  - key0 = 2b7e151628aed2a6abf7158809cf4f3c and key0_valid=1 after round 0;
  - key0_valid clears on the next load.
